// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline sequencer: FSM state encoding and the
// stage indices used for the en/flush bundles.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_WAIT = 2'd1
  } state_t;

  localparam int IF_ID    = 0;
  localparam int ID_EX    = 1;
  localparam int EX_MEM   = 2;
  localparam int MEM_WB   = 3;
  localparam int N_STAGES = 4;

  typedef logic [N_STAGES-1:0] stage_vec_t;

endpackage

// File: rtl/pipe_load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination is a
// non-zero register read by the instruction currently in ID.
module pipe_load_use_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  output logic                  hazard
);

  // x0 is hardwired to zero, so a load targeting it can never create a dependency.
  assign hazard = ex_mem_read && (ex_rd != '0) &&
                  ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central 5-stage pipeline sequencer: per-stage en/flush and PC enable from
// memory freeze, multiply countdown, taken branch and load-use hazards.
// Optional performance counters are enabled with `define PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MUL_LAT    = 3,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  ex_mul_start,
  input  logic                  mem_busy,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_en,
  output logic                  id_ex_flush,
  output logic                  ex_mem_en,
  output logic                  ex_mem_flush,
  output logic                  mem_wb_en,
  output logic                  mem_wb_flush
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_events
`endif
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  stage_vec_t       en, flush;
  logic             load_use;
  logic             mul_stall;
  logic             branch_flush;

  pipe_load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_load_use (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .hazard      (load_use)
  );

  // ex_mul_start is only honoured in RUN; MUL_WAIT runs off the countdown alone.
  assign mul_stall = ((state_q == RUN) && ex_mul_start && (MUL_LAT > 1)) ||
                     ((state_q == MUL_WAIT) && (cnt_q != '0));

  always_comb begin
    // NOTE: every variable gets a default before the priority chain so no path can infer a latch.
    en           = '1;
    flush        = '0;
    pc_en        = 1'b1;
    state_d      = state_q;
    cnt_d        = cnt_q;
    branch_flush = 1'b0;

    if (arst || mem_busy) begin
      en    = '0;
      pc_en = 1'b0;
    end else if (mul_stall) begin
      pc_en         = 1'b0;
      en[IF_ID]     = 1'b0;
      en[ID_EX]     = 1'b0;
      flush[EX_MEM] = 1'b1;
      if (state_q == RUN) begin
        state_d = MUL_WAIT;
        cnt_d   = CNT_W'(MUL_LAT - 2);
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else if (state_q == MUL_WAIT) begin
      // Release cycle: EX/MEM captures the product with default controls.
      state_d = RUN;
    end else if (ex_branch_taken) begin
      flush[IF_ID] = 1'b1;
      flush[ID_EX] = 1'b1;
      branch_flush = 1'b1;
    end else if (load_use) begin
      pc_en        = 1'b0;
      en[IF_ID]    = 1'b0;
      flush[ID_EX] = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign if_id_en     = en[IF_ID];
  assign if_id_flush  = flush[IF_ID];
  assign id_ex_en     = en[ID_EX];
  assign id_ex_flush  = flush[ID_EX];
  assign ex_mem_en    = en[EX_MEM];
  assign ex_mem_flush = flush[EX_MEM];
  assign mem_wb_en    = en[MEM_WB];
  assign mem_wb_flush = flush[MEM_WB];

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  // Counters keep running through a memory freeze; they wrap naturally.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!pc_en)       stall_cycles <= stall_cycles + 32'd1;
      if (branch_flush) flush_events <= flush_events + 32'd1;
    end
  end
`endif

endmodule
